// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: EX->MEM register, stalled-load data hold, load lane select
module mem_stage #(
    parameter int EX_TO_MEM_WD = 147,
    parameter int MEM_TO_WB_WD = 136,
    parameter int MEM_TO_RF_WD = 104,
    parameter int StallBus     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [StallBus-1:0]     stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic [MEM_TO_RF_WD-1:0] mem_to_rf_bus
);

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus_r;
    logic [31:0]             rdata_r;
    logic                    rdata_vld;

    // Field breakout of the registered EX->MEM bundle
    logic [4:0]  load_op;
    logic [65:0] hilo_bus;
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;

    assign {load_op, hilo_bus, pc, data_ram_en, data_ram_wen,
            sel_rf_res, rf_we, rf_waddr, ex_result} = ex_to_mem_bus_r;

    // Store enables complete in EX; only the stall bits for EX and MEM matter here
    logic unused_fields;
    assign unused_fields = &{1'b0, data_ram_en, data_ram_wen, stall[5], stall[2:0]};

    logic ex_held;
    logic mem_held;
    logic is_load;
    assign ex_held  = (stall[3] == Stop);
    assign mem_held = (stall[4] == Stop);
    assign is_load  = |load_op;

    // Pipeline register: reset, bubble when EX stalls but MEM moves, load, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_to_mem_bus_r <= '0;
        end else if (ex_held && !mem_held) begin
            ex_to_mem_bus_r <= '0;
        end else if (!ex_held) begin
            ex_to_mem_bus_r <= ex_to_mem_bus;
        end
    end

    // Capture the SRAM word on the first stalled MEM cycle of a load and freeze it
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_r   <= 32'h0;
            rdata_vld <= 1'b0;
        end else if (!ex_held || !mem_held) begin
            rdata_vld <= 1'b0;
        end else if (!rdata_vld && is_load) begin
            rdata_r   <= data_sram_rdata;
            rdata_vld <= 1'b1;
        end
    end

    logic [31:0] rd;
    assign rd = rdata_vld ? rdata_r : data_sram_rdata;

    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_data;
    logic [31:0] rf_wdata;

    // Byte/halfword lane select and sign/zero extension by one-hot {lb, lbu, lh, lhu, lw}
    always_comb begin
        byte_v    = 8'h0;
        half_v    = 16'h0;
        load_data = rd;
        case (ex_result[1:0])
            2'd0:    byte_v = rd[7:0];
            2'd1:    byte_v = rd[15:8];
            2'd2:    byte_v = rd[23:16];
            default: byte_v = rd[31:24];
        endcase
        half_v = ex_result[1] ? rd[31:16] : rd[15:0];
        if (load_op[4]) begin
            load_data = {{24{byte_v[7]}}, byte_v};
        end else if (load_op[3]) begin
            load_data = {24'h0, byte_v};
        end else if (load_op[2]) begin
            load_data = {{16{half_v[15]}}, half_v};
        end else if (load_op[1]) begin
            load_data = {16'h0, half_v};
        end
    end

    assign rf_wdata = sel_rf_res ? load_data : ex_result;

    assign mem_to_wb_bus = {hilo_bus, pc, rf_we, rf_waddr, rf_wdata};
    assign mem_to_rf_bus = {hilo_bus, rf_we, rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage with directed and random loads
module tb_mem_stage;

    logic         clk;
    logic         rst;
    logic [5:0]   stall;
    logic [146:0] ex_to_mem_bus;
    logic [31:0]  data_sram_rdata;
    logic [135:0] mem_to_wb_bus;
    logic [103:0] mem_to_rf_bus;

    mem_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_rdata (data_sram_rdata),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .mem_to_rf_bus   (mem_to_rf_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [4:0] OP_LB  = 5'b10000;
    localparam logic [4:0] OP_LBU = 5'b01000;
    localparam logic [4:0] OP_LH  = 5'b00100;
    localparam logic [4:0] OP_LHU = 5'b00010;
    localparam logic [4:0] OP_LW  = 5'b00001;

    int checks   = 0;
    int failures = 0;

    logic [135:0] exp_q[$];

    // Reference model: the instruction currently in MEM and the word it saw when first stalled
    logic [146:0] m_bus;
    logic         m_held;
    logic [31:0]  m_word;

    task automatic chk(input string name, input logic [135:0] got, input logic [135:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [146:0] mkbus(input logic [4:0] op, input logic sel, input logic we,
                                           input logic [4:0] waddr, input logic [31:0] res,
                                           input logic [65:0] hilo, input logic [31:0] pc);
        return {op, hilo, pc, |op, 4'h0, sel, we, waddr, res};
    endfunction

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        logic [31:0] lim;
        lim = 32'h1 << (bits - 1);
        if (v >= lim) return v | ~((lim << 1) - 32'h1);
        return v;
    endfunction

    function automatic logic [31:0] lane(input logic [4:0] op, input logic [31:0] addr, input logic [31:0] rd);
        logic [31:0] b;
        logic [31:0] h;
        b = (rd >> (8 * (addr % 4))) & 32'hFF;
        h = ((addr % 4) >= 2) ? (rd >> 16) : (rd & 32'hFFFF);
        case (op)
            OP_LB:   return sext(b, 8);
            OP_LBU:  return b;
            OP_LH:   return sext(h, 16);
            OP_LHU:  return h;
            default: return rd;
        endcase
    endfunction

    // Advance the model across one clock edge using the inputs that were sampled there
    task automatic model_step();
        if (rst) begin
            m_bus = '0; m_held = 1'b0; m_word = 32'h0;
        end else if (stall[3] == 1'b0) begin
            m_bus = ex_to_mem_bus; m_held = 1'b0;
        end else if (stall[4] == 1'b0) begin
            m_bus = '0; m_held = 1'b0;
        end else if (!m_held && m_bus[146:142] != 5'b0) begin
            m_held = 1'b1; m_word = data_sram_rdata;
        end
    endtask

    function automatic logic [135:0] model_out();
        logic [31:0] rd;
        logic [31:0] wd;
        rd = m_held ? m_word : data_sram_rdata;
        wd = m_bus[38] ? lane(m_bus[146:142], m_bus[31:0], rd) : m_bus[31:0];
        return {m_bus[141:76], m_bus[75:44], m_bus[37], m_bus[36:32], wd};
    endfunction

    // One cycle: model the edge, drive new inputs, queue the expected outputs for this cycle
    task automatic cyc(input logic r, input logic [5:0] s, input logic [146:0] b, input logic [31:0] d);
        @(posedge clk);
        #1;
        model_step();
        rst = r; stall = s; ex_to_mem_bus = b; data_sram_rdata = d;
        exp_q.push_back(model_out());
    endtask

    task automatic chk_wdata(input string name, input logic [31:0] exp);
        #2;
        chk(name, {104'h0, mem_to_wb_bus[31:0]}, {104'h0, exp});
    endtask

    // Monitor: every cycle the stage presents a result; compare both buses against the model
    initial begin
        logic [135:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wb_bus", mem_to_wb_bus, e);
                chk("rf_bus", {32'h0, mem_to_rf_bus}, {32'h0, e[135:70], e[37:0]});
            end
        end
    end

    task automatic load_test(input string name, input logic [4:0] op, input logic [31:0] addr,
                             input logic [31:0] word, input logic [31:0] exp);
        cyc(1'b0, 6'b0, mkbus(op, 1'b1, 1'b1, 5'd9, addr, 66'h0, 32'h400), 32'h0);
        cyc(1'b0, 6'b0, '0, word);
        chk_wdata(name, exp);
    endtask

    logic [146:0] rb;
    logic [146:0] bub_b;
    logic [65:0]  hl;

    initial begin
        m_bus = '0; m_held = 1'b0; m_word = 32'h0;
        rst = 1'b1; stall = 6'b0; data_sram_rdata = 32'hCAFEF00D;
        ex_to_mem_bus = mkbus(OP_LW, 1'b1, 1'b1, 5'd3, 32'h55, 66'h3_1234_5678_9ABC_DEF0, 32'h100);

        // Reset with a nonzero bus on the input
        cyc(1'b1, 6'b0, ex_to_mem_bus, 32'hCAFEF00D);
        #2;
        chk("reset_wb", mem_to_wb_bus, 136'h0);
        chk("reset_rf", {32'h0, mem_to_rf_bus}, 136'h0);
        cyc(1'b0, 6'b0, '0, 32'h0);
        #2;
        chk("reset_wb2", mem_to_wb_bus, 136'h0);

        load_test("lb",  OP_LB,  32'h1003, 32'h80FF1234, 32'hFFFFFF80);
        load_test("lbu", OP_LBU, 32'h1003, 32'h80FF1234, 32'h00000080);
        load_test("lh",  OP_LH,  32'h2002, 32'h9ABC5678, 32'hFFFF9ABC);
        load_test("lhu", OP_LHU, 32'h2002, 32'h9ABC5678, 32'h00009ABC);
        load_test("lw",  OP_LW,  32'h2002, 32'h9ABC5678, 32'h9ABC5678);

        // Stalled load keeps the first-cycle SRAM word; the next load sees fresh data
        cyc(1'b0, 6'b0, mkbus(OP_LW, 1'b1, 1'b1, 5'd4, 32'h3000, 66'h0, 32'h500), 32'h0);
        rb = mkbus(OP_LW, 1'b1, 1'b1, 5'd5, 32'h3004, 66'h0, 32'h504);
        cyc(1'b0, 6'b011111, rb, 32'hDEADBEEF);
        chk_wdata("stall_c1", 32'hDEADBEEF);
        cyc(1'b0, 6'b011111, rb, 32'h11111111);
        chk_wdata("stall_c2", 32'hDEADBEEF);
        cyc(1'b0, 6'b011111, rb, 32'h11111111);
        chk_wdata("stall_c3", 32'hDEADBEEF);
        cyc(1'b0, 6'b0, rb, 32'h11111111);
        chk_wdata("stall_c4", 32'hDEADBEEF);
        cyc(1'b0, 6'b0, '0, 32'h22222222);
        chk_wdata("after_release", 32'h22222222);

        // Bubble insert then full hold
        hl = {1'b1, 1'b1, 32'h0BAD_0BAD, 32'h1357_2468};
        cyc(1'b0, 6'b0, mkbus(5'b0, 1'b0, 1'b1, 5'd7, 32'h77, hl, 32'h600), 32'h0);
        cyc(1'b0, 6'b001111, mkbus(5'b0, 1'b0, 1'b1, 5'd8, 32'h88, hl, 32'h604), 32'h0);
        #2;
        chk("pre_bubble_we", {135'h0, mem_to_wb_bus[37]}, 136'h1);
        bub_b = mkbus(5'b0, 1'b0, 1'b1, 5'd10, 32'hAA, hl, 32'h608);
        cyc(1'b0, 6'b0, bub_b, 32'h0);
        #2;
        chk("bubble_we", {135'h0, mem_to_wb_bus[37]}, 136'h0);
        chk("bubble_hilo", {70'h0, mem_to_wb_bus[135:70]}, 136'h0);
        cyc(1'b0, 6'b011111, mkbus(5'b0, 1'b0, 1'b1, 5'd11, 32'hBB, 66'h0, 32'h60C), 32'h0);
        cyc(1'b0, 6'b0, mkbus(5'b0, 1'b0, 1'b1, 5'd12, 32'hCC, 66'h0, 32'h610), 32'h0);
        #2;
        chk("hold_waddr", {131'h0, mem_to_wb_bus[36:32]}, 136'd10);
        chk("hold_hilo", {70'h0, mem_to_wb_bus[135:70]}, {70'h0, hl});

        // Non-load passthrough with a HI write request
        hl = {1'b1, 1'b0, 32'hAAAA5555, 32'h0};
        cyc(1'b0, 6'b0, mkbus(5'b0, 1'b0, 1'b1, 5'd2, 32'h12345678, hl, 32'h700), 32'h0);
        cyc(1'b0, 6'b0, '0, 32'hFFFFFFFF);
        chk_wdata("pass_wdata", 32'h12345678);
        chk("pass_hilo_wb", {70'h0, mem_to_wb_bus[135:70]}, {70'h0, hl});
        chk("pass_hilo_rf", {70'h0, mem_to_rf_bus[103:38]}, {70'h0, hl});

        // Randomized traffic with stalls, bubbles and occasional reset
        for (int i = 0; i < 400; i++) begin
            logic [4:0] op;
            logic [5:0] s;
            int k;
            k = $urandom_range(0, 5);
            op = (k == 0) ? 5'b0 : (5'b1 << (k - 1));
            k = $urandom_range(0, 9);
            s = (k < 5) ? 6'b0 : (k < 7) ? 6'b001111 : 6'b011111;
            rb = mkbus(op, (op != 5'b0) ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       5'($urandom), $urandom, {2'($urandom), $urandom, $urandom}, $urandom);
            cyc(($urandom_range(0, 49) == 0), s, rb, $urandom);
        end

        cyc(1'b0, 6'b0, '0, 32'h0);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage of the five-stage MIPS core, between EX and WB. Registers the EX→MEM bus under the global stall vector, takes the synchronous data-SRAM read word for loads, and does byte/halfword lane selection with sign or zero extension. Holds the SRAM word across stall cycles so a stalled load does not lose its data. Drives the MEM→WB bus and the MEM→ID forwarding bus, with the HI/LO write request carried through unchanged.

## Interface
- `EX_TO_MEM_WD`, 147: EX→MEM bus width; `{load_op[4:0] (146:142), hilo_bus[65:0], pc[31:0], data_ram_en, data_ram_wen[3:0], sel_rf_res, rf_we, rf_waddr[4:0], ex_result[31:0]}`.
- `MEM_TO_WB_WD`, 136: `{hilo_bus[65:0], pc[31:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}`.
- `MEM_TO_RF_WD`, 104: `{hilo_bus[65:0], rf_we, rf_waddr[4:0], rf_wdata[31:0]}`.
- `StallBus`, 6: width of the global stall vector; `Stop`=1, `NoStop`=0.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `stall` in `StallBus`: `stall[3]` = EX held, `stall[4]` = MEM held.
- `ex_to_mem_bus` in `EX_TO_MEM_WD`: EX result bundle. `load_op` is one-hot `{lb, lbu, lh, lhu, lw}`.
- `data_sram_rdata` in 32: SRAM read word, valid the cycle after the address was presented from EX.
- `mem_to_wb_bus` out `MEM_TO_WB_WD`: to WB.
- `mem_to_rf_bus` out `MEM_TO_RF_WD`: forwarding to ID, combinational from the MEM register.

## Operation
- Pipeline register `ex_to_mem_bus_r`, updated at posedge, in priority order:
  - `rst`: cleared to 0.
  - `stall[3]==Stop && stall[4]==NoStop`: cleared to 0, a bubble. The bubble has `rf_we=0`, `hi_we=0` and `lo_we=0`.
  - `stall[3]==NoStop`: loads `ex_to_mem_bus`.
  - Otherwise: holds its value.
- Read-data hold register `rdata_r[31:0]` with valid flag `rdata_vld`:
  - `rst`: `rdata_r=0`, `rdata_vld=0`.
  - The MEM register loads or takes a bubble: `rdata_vld` is cleared to 0.
  - `stall[4]==Stop`, `rdata_vld==0` and the register holds a load (`|load_op`): `rdata_r` takes `data_sram_rdata` and `rdata_vld` is set to 1.
  - `rdata_r` is frozen while `rdata_vld==1`.
- Effective read word: `rd = rdata_vld ? rdata_r : data_sram_rdata`.
- Lane select, with `a = ex_result[1:0]`:
  - `lb`/`lbu`: byte `rd[8a+7:8a]`, sign-extended (`lb`) or zero-extended (`lbu`).
  - `lh`/`lhu`: `a[1]=0` selects `rd[15:0]`, `a[1]=1` selects `rd[31:16]`; sign- or zero-extended. `a[0]` is ignored.
  - `lw`: `rd`; `a` is ignored.
  - No misalignment exception is raised.
- `rf_wdata = sel_rf_res ? load_data : ex_result`. If `sel_rf_res=1` with `load_op==0`, `load_data=rd`.
- `hilo_bus`, `pc`, `rf_we` and `rf_waddr` pass from the register unchanged.
- `data_ram_en` and `data_ram_wen` are registered but not used for output logic. Stores complete in EX.

## Timing
- All outputs are 0 after reset; a reset bubble gives `rf_we=0` and `hilo_bus=0`.
- Latency: one register stage. The MEM→WB outputs are combinational from `ex_to_mem_bus_r` and `rd`.
- Within a cycle, `mem_to_rf_bus` equals the `rf_*` and `hilo` fields of `mem_to_wb_bus`.
- SRAM read data is used in the first MEM cycle directly. From the second consecutive stalled MEM cycle onward, `rdata_r` is used.
- Simultaneous `rst` and a stall: `rst` wins.
- A bubble insert on the same edge as `rdata_vld` capture: the bubble wins and `rdata_vld=0`.
- `stall[3]==Stop && stall[4]==Stop`: the register and `rdata_r` both hold, for any number of cycles.

## Test plan
- Reset:
  - Stimulus: assert `rst` 2 cycles with nonzero `ex_to_mem_bus`.
  - Required: `mem_to_wb_bus==0`, `mem_to_rf_bus==0`.
- `lb`, sign extension:
  - Stimulus: `ex_result=0x1003`, `rdata=0x80FF1234`.
  - Required: `rf_wdata=0xFFFFFF80`.
  - Same with `lbu`: `0x00000080`.
- `lh`, upper half:
  - Stimulus: `ex_result=0x2002`, `rdata=0x9ABC5678`.
  - Required: `rf_wdata=0xFFFF9ABC`.
  - Same with `lhu`: `0x00009ABC`.
  - Same with `lw`: `0x9ABC5678`.
- Stalled load:
  - Stimulus: `lw` enters MEM with `rdata=0xDEADBEEF`; next cycle `stall[4]=Stop` for 3 cycles while `rdata` changes to `0x11111111`.
  - Required: `rf_wdata` stays `0xDEADBEEF` throughout.
  - After release and a new instruction: `rdata_vld=0`.
- Bubble insert:
  - Stimulus: `stall=6'b001111` one cycle with `rf_we=1` on input.
  - Required: next cycle `rf_we=0`, `hilo_bus=0`.
  - Stimulus: `stall=6'b011111`.
  - Required: previous contents held.
- Non-load passthrough:
  - Stimulus: `sel_rf_res=0`, `ex_result=0x12345678`, `hi_we=1`, `hi=0xAAAA5555`.
  - Required: `rf_wdata=0x12345678`; `hilo_bus` identical on both outputs.
